stream_mux_n_1: RTL and testbench

Parametrised N-input, WIDTH-bit registered stream multiplexer with valid/ready handshaking on every port. It selects one source per beat, either by an explicit select input (fixed mode) or by a round-robin arbiter, and buffers the chosen beat in a one-deep output register. It is the next generation of the team's 2:1 combinational mux: wider, N-way and flow-controlled, with optional packet locking. It sits between multiple producers and a single downstream consumer.

---
 rtl/stream_mux_n_1.sv | 177 +++++++++++++++++
 tb/tb_stream_mux_n_1.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stream_mux_n_1.sv
`default_nettype none
// ============================================================================
// Module  : stream_mux_n_1
// Brief   : N:1 registered valid/ready stream mux, fixed-select or round-robin.
//           Optional packet locking when MUX_PKT_LOCK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module stream_mux_n_1 #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [N-1:0]           in_valid,
`ifdef MUX_PKT_LOCK_EN
    input  logic [N-1:0]           in_last,
    output logic                   out_last,
`endif
    output logic [N-1:0]           in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   out_chan
);
    localparam int SEL_W = $clog2(N);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             load_en;
    logic             rr_vld;
    logic [SEL_W-1:0] rr_gnt;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

`ifdef MUX_PKT_LOCK_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_q, lock_d;
    logic             out_last_q, out_last_d;
    logic             gnt_last;
`endif

    assign load_en = !out_valid_q || out_ready;

    // Cyclic search starting just after the last-served channel.
    always_comb begin
        rr_vld = 1'b0;
        rr_gnt = '0;
        for (int k = 1; k <= N; k++) begin
            if (!rr_vld && in_valid[(int'(ptr_q) + k) % N]) begin
                rr_vld = 1'b1;
                rr_gnt = SEL_W'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        gnt     = sel;
        gnt_vld = (int'(sel) < N);
        if (mode) begin
            gnt     = rr_gnt;
            gnt_vld = rr_vld;
        end
`ifdef MUX_PKT_LOCK_EN
        if (state_q == ST_LOCKED) begin
            gnt     = lock_q;
            gnt_vld = 1'b1;
        end
`endif
    end

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
`ifdef MUX_PKT_LOCK_EN
        gnt_last = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            if (gnt == SEL_W'(i)) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = gnt_vld && load_en && !rst;
`ifdef MUX_PKT_LOCK_EN
                gnt_last    = in_last[i];
`endif
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    always_comb begin
        ptr_d       = ptr_q;
        out_chan_d  = out_chan_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            ptr_d       = gnt;
            out_chan_d  = gnt;
            out_data_d  = gnt_data;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        out_last_d = out_last_q;
        if (xfer) begin
            out_last_d = gnt_last;
            case (state_q)
                ST_IDLE: begin
                    if (!gnt_last) begin
                        state_d = ST_LOCKED;
                        lock_d  = gnt;
                    end
                end
                ST_LOCKED: begin
                    if (gnt_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lock_q     <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

    // ptr resets to N-1 so channel 0 wins the first round-robin search.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= SEL_W'(N - 1);
            out_chan_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_chan_q  <= out_chan_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_n_1.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_mux_n_1
// Brief   : Table-driven bench for stream_mux_n_1 (WIDTH=8, N=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_mux_n_1;
    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic             clk;
    logic             rst;
    logic             mode;
    logic [1:0]       sel;
    logic [31:0]      in_data;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_chan;
`ifdef MUX_PKT_LOCK_EN
    logic [3:0]       in_last;
    logic             out_last;
`endif

    int errors = 0;
    int checks = 0;

    stream_mux_n_1 #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_oc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; in_ready is sampled before the
    // rising edge, registered outputs just after it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst       = v.rst;
        mode      = v.mode;
        sel       = v.sel;
        in_valid  = v.vld;
        in_data   = v.data;
        out_ready = v.ordy;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        check({tag, ".out_data"},  32'(out_data),  32'(v.exp_od));
        check({tag, ".out_chan"},  32'(out_chan),  32'(v.exp_oc));
    endtask

`ifdef MUX_PKT_LOCK_EN
    task automatic lstep(input logic [3:0] vld, input logic [31:0] data, input logic [3:0] last,
                         input logic [3:0] e_rdy, input logic [7:0] e_od, input logic [1:0] e_oc,
                         input logic e_ol, input string tag);
        @(negedge clk);
        rst       = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = vld;
        in_data   = data;
        in_last   = last;
        out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out_data"},  32'(out_data),  32'(e_od));
        check({tag, ".out_chan"},  32'(out_chan),  32'(e_oc));
        check({tag, ".out_last"},  32'(out_last),  32'(e_ol));
    endtask
`endif

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
`ifdef MUX_PKT_LOCK_EN
        in_last = 4'b1111;
`endif
        //              rst  mode sel  vld      data          ordy  rdy      ov    od     oc
        // reset with all channels valid
        vecs.push_back('{1'b1,1'b0,2'd0,4'b1111,32'h13121110,1'b1,4'b0000,1'b0,8'h00,2'd0});
        vecs.push_back('{1'b1,1'b1,2'd0,4'b1111,32'h13121110,1'b1,4'b0000,1'b0,8'h00,2'd0});
        // fixed select ch2, then drain with ready independent of valid
        vecs.push_back('{1'b0,1'b0,2'd2,4'b0100,32'h00A50000,1'b1,4'b0100,1'b1,8'hA5,2'd2});
        vecs.push_back('{1'b0,1'b0,2'd2,4'b0000,32'h00000000,1'b1,4'b0100,1'b0,8'hA5,2'd2});
        // round-robin 0,1,2,3,0 from reset
        vecs.push_back('{1'b1,1'b1,2'd0,4'b1111,32'h13121110,1'b1,4'b0000,1'b0,8'h00,2'd0});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b1111,32'h13121110,1'b1,4'b0001,1'b1,8'h10,2'd0});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b1111,32'h13121110,1'b1,4'b0010,1'b1,8'h11,2'd1});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b1111,32'h13121110,1'b1,4'b0100,1'b1,8'h12,2'd2});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b1111,32'h13121110,1'b1,4'b1000,1'b1,8'h13,2'd3});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b1111,32'h13121110,1'b1,4'b0001,1'b1,8'h10,2'd0});
        // backpressure: 0x3C held three cycles, next beat loads on release
        vecs.push_back('{1'b0,1'b0,2'd1,4'b0010,32'h00003C00,1'b1,4'b0010,1'b1,8'h3C,2'd1});
        vecs.push_back('{1'b0,1'b0,2'd1,4'b0010,32'h00007700,1'b0,4'b0000,1'b1,8'h3C,2'd1});
        vecs.push_back('{1'b0,1'b0,2'd1,4'b0010,32'h00007700,1'b0,4'b0000,1'b1,8'h3C,2'd1});
        vecs.push_back('{1'b0,1'b0,2'd1,4'b0010,32'h00007700,1'b0,4'b0000,1'b1,8'h3C,2'd1});
        vecs.push_back('{1'b0,1'b0,2'd1,4'b0010,32'h00007700,1'b1,4'b0010,1'b1,8'h77,2'd1});
        // round-robin over ch1/ch3 only, then ch1 alone
        vecs.push_back('{1'b1,1'b1,2'd0,4'b1010,32'h23002100,1'b1,4'b0000,1'b0,8'h00,2'd0});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b1010,32'h23002100,1'b1,4'b0010,1'b1,8'h21,2'd1});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b1010,32'h23002100,1'b1,4'b1000,1'b1,8'h23,2'd3});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b1010,32'h23002100,1'b1,4'b0010,1'b1,8'h21,2'd1});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b1010,32'h23002100,1'b1,4'b1000,1'b1,8'h23,2'd3});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b0010,32'h23002100,1'b1,4'b0010,1'b1,8'h21,2'd1});
        vecs.push_back('{1'b0,1'b1,2'd0,4'b0010,32'h23002100,1'b1,4'b0010,1'b1,8'h21,2'd1});
        // no valid in round-robin: no grant, register drains
        vecs.push_back('{1'b0,1'b1,2'd0,4'b0000,32'h00000000,1'b1,4'b0000,1'b0,8'h21,2'd1});
        // mid-stream reset discards the held beat
        vecs.push_back('{1'b0,1'b1,2'd0,4'b0001,32'h00000055,1'b1,4'b0001,1'b1,8'h55,2'd0});
        vecs.push_back('{1'b1,1'b1,2'd0,4'b0001,32'h00000055,1'b0,4'b0000,1'b0,8'h00,2'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // mode/sel change under backpressure must not disturb the held beat
        apply('{1'b0,1'b0,2'd3,4'b1000,32'h99000000,1'b0,4'b1000,1'b1,8'h99,2'd3}, "hold0");
        apply('{1'b0,1'b1,2'd0,4'b0001,32'h00000044,1'b0,4'b0000,1'b1,8'h99,2'd3}, "hold1");
        apply('{1'b0,1'b1,2'd0,4'b0001,32'h00000044,1'b1,4'b0001,1'b1,8'h44,2'd0}, "hold2");

`ifdef MUX_PKT_LOCK_EN
        apply('{1'b1,1'b1,2'd0,4'b0011,32'h0,1'b1,4'b0000,1'b0,8'h00,2'd0}, "lrst");
        lstep(4'b0011, 32'h0000C1B0, 4'b1110, 4'b0001, 8'hB0, 2'd0, 1'b0, "pkt0");
        lstep(4'b0011, 32'h0000C1B1, 4'b1110, 4'b0001, 8'hB1, 2'd0, 1'b0, "pkt1");
        lstep(4'b0011, 32'h0000C1B2, 4'b1111, 4'b0001, 8'hB2, 2'd0, 1'b1, "pkt2");
        lstep(4'b0010, 32'h0000C100, 4'b1111, 4'b0010, 8'hC1, 2'd1, 1'b1, "pkt3");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
